// File: rtl/instruction_issue_queue_pkg.sv
// Shared types for the decode-and-issue queue: opcodes, decoded operation layout,
// queue entry and issue bus records, plus the instruction field decoder.
package instruction_issue_queue_pkg;

  localparam int NUM_UNITS = 3;

  localparam logic [6:0] ARITH     = 7'b0110011;
  localparam logic [6:0] ARITH_IMM = 7'b0010011;
  localparam logic [6:0] LOAD      = 7'b0000011;
  localparam logic [6:0] STORE     = 7'b0100011;
  localparam logic [6:0] BRANCH    = 7'b1100011;

  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_BU  = 2'd1,
    FU_LSU = 2'd2
  } e_functional_unit;

  typedef enum logic [1:0] {
    FMT_R  = 2'd0,
    FMT_I  = 2'd1,
    FMT_SB = 2'd2
  } e_format;

  // All union members are 45 bits wide; immediates are sign-extended to 32 bits.
  typedef struct packed {
    logic [19:0] pad;
    logic [6:0]  funct7;
    logic [4:0]  rs2;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic [4:0]  rd;
  } r_format_t;

  typedef struct packed {
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic [4:0]  rd;
  } i_format_t;

  typedef struct packed {
    logic [31:0] imm;
    logic [4:0]  rs2;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
  } sb_format_t;

  typedef union packed {
    r_format_t  R;
    i_format_t  I;
    sb_format_t SB;
  } u_spec;

  typedef struct packed {
    logic [6:0] opcode;
    e_format    fmt;
    u_spec      spec;
  } operation_specification;

  typedef struct packed {
    e_functional_unit       rs_id;
    operation_specification op;
  } issue_queue_entry;

  typedef struct packed {
    logic                   valid;
    e_functional_unit       rs_id;
    operation_specification op;
  } issue_bus_t;

  function automatic operation_specification decode_instruction(input logic [31:0] instr,
                                                                input e_format     fmt);
    operation_specification op;
    op        = '0;
    op.opcode = instr[6:0];
    op.fmt    = fmt;
    case (fmt)
      FMT_R: begin
        op.spec.R.funct7 = instr[31:25];
        op.spec.R.rs2    = instr[24:20];
        op.spec.R.rs1    = instr[19:15];
        op.spec.R.funct3 = instr[14:12];
        op.spec.R.rd     = instr[11:7];
      end
      FMT_I: begin
        op.spec.I.imm    = {{20{instr[31]}}, instr[31:20]};
        op.spec.I.rs1    = instr[19:15];
        op.spec.I.funct3 = instr[14:12];
        op.spec.I.rd     = instr[11:7];
      end
      default: begin
        op.spec.SB.rs2    = instr[24:20];
        op.spec.SB.rs1    = instr[19:15];
        op.spec.SB.funct3 = instr[14:12];
        // Branch offsets are scrambled and halfword aligned; store offsets are split in two.
        if (instr[6:0] == BRANCH)
          op.spec.SB.imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        else
          op.spec.SB.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
    endcase
    return op;
  endfunction

endpackage

// File: rtl/instruction_issue_queue_format_decoder.sv
// Maps an opcode to its instruction format and the reservation station that executes it.
module instruction_format_decoder
  import instruction_issue_queue_pkg::*;
(
  input  logic [6:0]       opcode,
  output e_format          fmt,
  output e_functional_unit unit
);

  always_comb begin
    fmt  = FMT_I;
    unit = FU_ALU;
    case (opcode)
      ARITH:     begin fmt = FMT_R;  unit = FU_ALU; end
      ARITH_IMM: begin fmt = FMT_I;  unit = FU_ALU; end
      LOAD:      begin fmt = FMT_I;  unit = FU_LSU; end
      STORE:     begin fmt = FMT_SB; unit = FU_LSU; end
      BRANCH:    begin fmt = FMT_SB; unit = FU_BU;  end
      default:   begin fmt = FMT_I;  unit = FU_ALU; end
    endcase
  end

endmodule

// File: rtl/instruction_issue_queue.sv
// In-order decode-and-issue FIFO between fetch and the reservation stations,
// with per-station stall, flush and illegal-opcode reporting.
module instruction_issue_queue
  import instruction_issue_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [31:0]                  instruction,
  input  logic                         instruction_valid,
  output logic                         instruction_ready,
  input  logic [NUM_UNITS-1:0]         rs_ready,
  input  logic                         flush,
  output issue_bus_t                   issue_bus,
  output logic                         illegal_instr,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             illegal_q, illegal_d;
  issue_queue_entry entries_q [DEPTH];

  e_format          dec_fmt;
  e_functional_unit dec_unit;
  issue_queue_entry new_entry;
  issue_queue_entry head_entry;
  logic             opcode_legal;
  logic             accept;
  logic             enq;
  logic             issue;

  instruction_format_decoder u_format_decoder (
    .opcode (instruction[6:0]),
    .fmt    (dec_fmt),
    .unit   (dec_unit)
  );

  always_comb begin
    opcode_legal      = instruction[6:0] inside {ARITH, ARITH_IMM, LOAD, STORE, BRANCH};
    new_entry.rs_id   = dec_unit;
    new_entry.op      = decode_instruction(instruction, dec_fmt);
    head_entry        = entries_q[head_q];

    // Ready depends only on registered occupancy, so a full queue stalls even while issuing.
    instruction_ready = (count_q != CW'(DEPTH));
    accept            = instruction_valid && instruction_ready && !flush;
    enq               = accept && opcode_legal;

    issue_bus.valid   = (count_q != '0) && !flush;
    issue_bus.rs_id   = head_entry.rs_id;
    issue_bus.op      = head_entry.op;
    issue             = issue_bus.valid && rs_ready[head_entry.rs_id];

    illegal_instr     = illegal_q;
    count             = count_q;
  end

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    illegal_d = accept && !opcode_legal;

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq)   tail_d = tail_q + PW'(1);
      if (issue) head_d = head_q + PW'(1);
      case ({enq, issue})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
    end
  end

  // Entry storage is deliberately left out of reset; count alone says what is live.
  always_ff @(posedge clk) begin
    if (enq) entries_q[tail_q] <= new_entry;
  end

endmodule

// File: tb/tb_instruction_issue_queue.sv
// Scoreboard bench for instruction_issue_queue: stimulus pushes hand-decoded
// expectations, a negedge monitor pops and compares every issued operation.
module tb_instruction_issue_queue;
  import instruction_issue_queue_pkg::*;

  localparam int DEPTH = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [31:0]           instruction;
  logic                  instruction_valid;
  logic                  instruction_ready;
  logic [NUM_UNITS-1:0]  rs_ready;
  logic                  flush;
  issue_bus_t            issue_bus;
  logic                  illegal_instr;
  logic [2:0]            count;

  typedef struct {
    logic [31:0]      instr;
    e_functional_unit rs_id;
    e_format          fmt;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [31:0]      imm;
  } exp_t;

  exp_t sb [$];
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;

  instruction_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .instruction       (instruction),
    .instruction_valid (instruction_valid),
    .instruction_ready (instruction_ready),
    .rs_ready          (rs_ready),
    .flush             (flush),
    .issue_bus         (issue_bus),
    .illegal_instr     (illegal_instr),
    .count             (count)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [31:0] instr, input e_functional_unit u,
                              input e_format f, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [31:0] imm);
    exp_t e;
    e.instr = instr; e.rs_id = u; e.fmt = f;
    e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      passes++;
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] instr, input exp_t e, input bit legal);
    instruction_valid = 1'b1;
    instruction       = instr;
    @(negedge clk);
    if (legal && instruction_ready && !flush) sb.push_back(e);
    nextCycle();
    instruction_valid = 1'b0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 20 && (sb.size() != 0 || count != 3'd0); i++) nextCycle();
    @(negedge clk);
    checkOutput("drain_scoreboard", 32'(sb.size()), 32'd0);
    checkOutput("drain_count", 32'(count), 32'd0);
  endtask

  // Monitor: every operation that actually issues must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && issue_bus.valid && rs_ready[issue_bus.rs_id]) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL unexpected_issue: got opcode %0h rs_id %0d, expected nothing",
                 issue_bus.op.opcode, issue_bus.rs_id);
      end else begin
        e = sb.pop_front();
        checkOutput($sformatf("rs_id[%08h]", e.instr), 32'(issue_bus.rs_id), 32'(e.rs_id));
        checkOutput($sformatf("fmt[%08h]", e.instr), 32'(issue_bus.op.fmt), 32'(e.fmt));
        checkOutput($sformatf("opcode[%08h]", e.instr), 32'(issue_bus.op.opcode), 32'(e.instr[6:0]));
        case (e.fmt)
          FMT_R: begin
            checkOutput($sformatf("R.rd[%08h]", e.instr), 32'(issue_bus.op.spec.R.rd), 32'(e.rd));
            checkOutput($sformatf("R.rs1[%08h]", e.instr), 32'(issue_bus.op.spec.R.rs1), 32'(e.rs1));
            checkOutput($sformatf("R.rs2[%08h]", e.instr), 32'(issue_bus.op.spec.R.rs2), 32'(e.rs2));
          end
          FMT_I: begin
            checkOutput($sformatf("I.rd[%08h]", e.instr), 32'(issue_bus.op.spec.I.rd), 32'(e.rd));
            checkOutput($sformatf("I.rs1[%08h]", e.instr), 32'(issue_bus.op.spec.I.rs1), 32'(e.rs1));
            checkOutput($sformatf("I.imm[%08h]", e.instr), issue_bus.op.spec.I.imm, e.imm);
          end
          default: begin
            checkOutput($sformatf("SB.rs1[%08h]", e.instr), 32'(issue_bus.op.spec.SB.rs1), 32'(e.rs1));
            checkOutput($sformatf("SB.rs2[%08h]", e.instr), 32'(issue_bus.op.spec.SB.rs2), 32'(e.rs2));
            checkOutput($sformatf("SB.imm[%08h]", e.instr), issue_bus.op.spec.SB.imm, e.imm);
          end
        endcase
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish within 100000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t none;
    exp_t addi5, add_op, lw_op, beq_op, sw_op;
    logic [31:0] instr_k;

    none   = mk(32'h0, FU_ALU, FMT_I, 5'd0, 5'd0, 5'd0, 32'd0);
    addi5  = mk(32'h00500093, FU_ALU, FMT_I,  5'd1, 5'd0, 5'd0, 32'd5);
    add_op = mk(32'h002081B3, FU_ALU, FMT_R,  5'd3, 5'd1, 5'd2, 32'd0);
    lw_op  = mk(32'h00812283, FU_LSU, FMT_I,  5'd5, 5'd2, 5'd0, 32'd8);
    beq_op = mk(32'h00208463, FU_BU,  FMT_SB, 5'd0, 5'd1, 5'd2, 32'd8);
    sw_op  = mk(32'h00512623, FU_LSU, FMT_SB, 5'd0, 5'd2, 5'd5, 32'd12);

    rst = 1'b1; instruction = '0; instruction_valid = 1'b0; rs_ready = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_count", 32'(count), 32'd0);
    checkOutput("reset_ready", 32'(instruction_ready), 32'd1);
    checkOutput("reset_valid", 32'(issue_bus.valid), 32'd0);
    checkOutput("reset_illegal", 32'(illegal_instr), 32'd0);
    nextCycle();
    rst = 1'b0;

    // Single addi: visible the cycle after acceptance, gone the cycle after that.
    rs_ready = 3'b111;
    applyStimulus(addi5.instr, addi5, 1'b1);
    @(negedge clk);
    checkOutput("addi_valid", 32'(issue_bus.valid), 32'd1);
    nextCycle();
    @(negedge clk);
    checkOutput("addi_count_after", 32'(count), 32'd0);
    nextCycle();

    // Fill to DEPTH with every station stalled, then release only the ALU.
    rs_ready = 3'b000;
    applyStimulus(add_op.instr, add_op, 1'b1);
    applyStimulus(lw_op.instr,  lw_op,  1'b1);
    applyStimulus(beq_op.instr, beq_op, 1'b1);
    applyStimulus(sw_op.instr,  sw_op,  1'b1);
    @(negedge clk);
    checkOutput("full_count", 32'(count), 32'd4);
    checkOutput("full_ready", 32'(instruction_ready), 32'd0);
    nextCycle();
    rs_ready = 3'b001;
    @(negedge clk);
    nextCycle();
    @(negedge clk);
    checkOutput("hol_count", 32'(count), 32'd3);
    checkOutput("hol_head_unit", 32'(issue_bus.rs_id), 32'(FU_LSU));
    nextCycle();
    @(negedge clk);
    checkOutput("hol_count_held", 32'(count), 32'd3);
    nextCycle();
    rs_ready = 3'b111;
    waitDrain();
    nextCycle();

    // Illegal LUI is consumed without occupying a slot.
    rs_ready = 3'b000;
    applyStimulus(add_op.instr, add_op, 1'b1);
    @(negedge clk);
    checkOutput("illegal_ready", 32'(instruction_ready), 32'd1);
    nextCycle();
    applyStimulus(32'h000010B7, none, 1'b0);
    @(negedge clk);
    checkOutput("illegal_pulse", 32'(illegal_instr), 32'd1);
    checkOutput("illegal_count", 32'(count), 32'd1);
    nextCycle();
    @(negedge clk);
    checkOutput("illegal_pulse_end", 32'(illegal_instr), 32'd0);
    nextCycle();
    rs_ready = 3'b111;
    waitDrain();
    nextCycle();

    // Flush with three queued and a same-cycle enqueue.
    rs_ready = 3'b000;
    applyStimulus(add_op.instr, add_op, 1'b1);
    applyStimulus(lw_op.instr,  lw_op,  1'b1);
    applyStimulus(beq_op.instr, beq_op, 1'b1);
    instruction_valid = 1'b1;
    instruction       = sw_op.instr;
    flush             = 1'b1;
    @(negedge clk);
    checkOutput("flush_count_before", 32'(count), 32'd3);
    checkOutput("flush_valid", 32'(issue_bus.valid), 32'd0);
    nextCycle();
    flush = 1'b0;
    instruction_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    checkOutput("flush_count_after", 32'(count), 32'd0);
    checkOutput("flush_valid_after", 32'(issue_bus.valid), 32'd0);
    checkOutput("flush_no_illegal", 32'(illegal_instr), 32'd0);
    nextCycle();
    rs_ready = 3'b111;
    repeat (3) nextCycle();

    // Back-to-back stream across pointer wrap with the ALU always ready.
    for (int k = 1; k <= 20; k++) begin
      instr_k = 32'h00000093 | (32'(k) << 20);
      instruction_valid = 1'b1;
      instruction       = instr_k;
      @(negedge clk);
      checks++;
      if (count > 3'd1) begin
        fails++;
        $display("[TB] FAIL stream_count[%0d]: got %0d, expected at most 1", k, count);
      end else begin
        passes++;
      end
      if (instruction_ready) sb.push_back(mk(instr_k, FU_ALU, FMT_I, 5'd1, 5'd0, 5'd0, 32'(k)));
      nextCycle();
    end

    // Asynchronous reset in the middle of a cycle, while still streaming.
    instruction = 32'h01500093;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_count", 32'(count), 32'd0);
    checkOutput("async_rst_valid", 32'(issue_bus.valid), 32'd0);
    checkOutput("async_rst_illegal", 32'(illegal_instr), 32'd0);
    checkOutput("async_rst_ready", 32'(instruction_ready), 32'd1);
    sb.delete();
    instruction_valid = 1'b0;
    @(negedge clk);
    nextCycle();
    rst = 1'b0;

    applyStimulus(addi5.instr, addi5, 1'b1);
    waitDrain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
